// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch-side handshake and status bundle for pc_sequencer
interface pc_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             imem_ready;
   logic             stall;
   logic             redirect_valid;
   logic [WIDTH-1:0] redirect_target;
   logic             exc_valid;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pc_plus_inc;
   logic             fetch_valid;
   logic             redirect_pending;
   logic             misaligned;

   modport master (
      output imem_ready, stall, redirect_valid, redirect_target, exc_valid,
      input  pc, pc_plus_inc, fetch_valid, redirect_pending, misaligned
   );

   modport slave (
      input  imem_ready, stall, redirect_valid, redirect_target, exc_valid,
      output pc, pc_plus_inc, fetch_valid, redirect_pending, misaligned
   );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter with redirect buffering and exception entry
// Optional MIPS-style branch delay slot when BRANCH_DELAY_SLOT_EN is defined.
module pc_sequencer #(
   parameter int               WIDTH      = 32,
   parameter int               INC        = 4,
   parameter logic [WIDTH-1:0] RESET_PC   = '0,
   parameter logic [31:0]      EXC_VECTOR = 32'h0000_0180
) (
   input logic           clk,
   input logic           rst,
   pc_sequencer_if.slave bus
);
   localparam logic [WIDTH-1:0] INC_W    = WIDTH'(INC);
   localparam logic [WIDTH-1:0] LOW_MASK = INC_W - WIDTH'(1);
   localparam logic [WIDTH-1:0] EXC_PC   = WIDTH'(EXC_VECTOR);

   typedef enum logic {ST_BOOT, ST_RUN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic             pend_q, pend_d;
   logic [WIDTH-1:0] pend_target_q, pend_target_d;
   logic [WIDTH-1:0] pc_plus;
   logic [WIDTH-1:0] aligned_target;
   logic             advance;
`ifdef BRANCH_DELAY_SLOT_EN
   // Set when the buffered redirect still owes its delay slot before the target.
   logic             slot_q, slot_d;
`endif

   assign pc_plus        = pc_q + INC_W;
   assign aligned_target = bus.redirect_target & ~LOW_MASK;
   assign advance        = (state_q == ST_RUN) & bus.imem_ready & ~bus.stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_BOOT;
         pc_q          <= RESET_PC;
         pend_q        <= 1'b0;
         pend_target_q <= '0;
`ifdef BRANCH_DELAY_SLOT_EN
         slot_q        <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         pend_q        <= pend_d;
         pend_target_q <= pend_target_d;
`ifdef BRANCH_DELAY_SLOT_EN
         slot_q        <= slot_d;
`endif
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      pend_d        = pend_q;
      pend_target_d = pend_target_q;
`ifdef BRANCH_DELAY_SLOT_EN
      slot_d        = slot_q;
`endif
      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         default: state_d = ST_RUN;
      endcase

      if (bus.exc_valid) begin
         pc_d   = EXC_PC;
         pend_d = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
         slot_d = 1'b0;
`endif
      end else if (bus.redirect_valid && advance) begin
`ifdef BRANCH_DELAY_SLOT_EN
         pc_d          = pc_plus;
         pend_d        = 1'b1;
         pend_target_d = aligned_target;
         slot_d        = 1'b0;
`else
         pc_d   = aligned_target;
         pend_d = 1'b0;
`endif
      end else if (bus.redirect_valid) begin
         pend_d        = 1'b1;
         pend_target_d = aligned_target;
`ifdef BRANCH_DELAY_SLOT_EN
         slot_d        = 1'b1;
`endif
      end else if (pend_q && advance) begin
`ifdef BRANCH_DELAY_SLOT_EN
         if (slot_q) begin
            pc_d   = pc_plus;
            slot_d = 1'b0;
         end else begin
            pc_d   = pend_target_q;
            pend_d = 1'b0;
         end
`else
         pc_d   = pend_target_q;
         pend_d = 1'b0;
`endif
      end else if (advance) begin
         pc_d = pc_plus;
      end
   end

   assign bus.pc               = pc_q;
   assign bus.pc_plus_inc      = pc_plus;
   assign bus.fetch_valid      = (state_q == ST_RUN);
   assign bus.redirect_pending = pend_q;
   assign bus.misaligned       = bus.redirect_valid & (|(bus.redirect_target & LOW_MASK));
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer at WIDTH 32 and WIDTH 8
module tb_pc_sequencer;
`ifdef BRANCH_DELAY_SLOT_EN
   localparam bit DS = 1'b1;
`else
   localparam bit DS = 1'b0;
`endif
   localparam logic [31:0] M32 = 32'hFFFF_FFFF;
   localparam logic [31:0] M8  = 32'h0000_00FF;
   localparam logic [31:0] EXC = 32'h0000_0180;

   typedef struct packed {
      logic [31:0] pc;
      logic        fv;
      logic        pv;
      logic [31:0] pt;
      logic        slot;
   } mstate_t;

   typedef struct packed {
      logic [31:0] pc;
      logic        fv;
      logic        pv;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_mis = 0;
   exp_t q32[$];
   exp_t q8[$];
   mstate_t m32, m8;

   pc_sequencer_if #(.WIDTH(32)) b32 ();
   pc_sequencer_if #(.WIDTH(8))  b8 ();

   pc_sequencer #(.WIDTH(32), .INC(4), .RESET_PC(32'h0), .EXC_VECTOR(EXC)) u_dut (
      .clk(clk), .rst(rst), .bus(b32)
   );
   pc_sequencer #(.WIDTH(8), .INC(4), .RESET_PC(8'h0), .EXC_VECTOR(EXC)) u_dut8 (
      .clk(clk), .rst(rst), .bus(b8)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_vec++;
      if (obs !== want) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, want);
      end
   endtask

   function automatic mstate_t model_next(input mstate_t s, input bit rdy, input bit stl,
                                          input bit rv, input logic [31:0] tgt, input bit exc,
                                          input logic [31:0] mask);
      mstate_t     n = s;
      bit          adv = s.fv && rdy && !stl;
      logic [31:0] tgt_al = tgt & mask & 32'hFFFF_FFFC;
      logic [31:0] seq = (s.pc + 32'd4) & mask;
      n.fv = 1'b1;
      if (exc) begin
         n.pc = EXC & mask; n.pv = 1'b0; n.slot = 1'b0;
      end else if (rv && adv) begin
         if (DS) begin
            n.pc = seq; n.pv = 1'b1; n.pt = tgt_al; n.slot = 1'b0;
         end else begin
            n.pc = tgt_al; n.pv = 1'b0;
         end
      end else if (rv) begin
         n.pv = 1'b1; n.pt = tgt_al; n.slot = 1'b1;
      end else if (s.pv && adv) begin
         if (DS && s.slot) begin
            n.pc = seq; n.slot = 1'b0;
         end else begin
            n.pc = s.pt; n.pv = 1'b0;
         end
      end else if (adv) begin
         n.pc = seq;
      end
      return n;
   endfunction

   function automatic mstate_t model_reset();
      mstate_t r;
      r = '0;
      return r;
   endfunction

   // Drive one cycle on both DUTs, push model predictions, then compare after the edge.
   task automatic step(input bit rdy, input bit stl, input bit rv, input logic [31:0] tgt,
                       input bit exc);
      mstate_t n32, n8;
      exp_t    e;
      b32.imem_ready = rdy; b32.stall = stl; b32.redirect_valid = rv;
      b32.redirect_target = tgt; b32.exc_valid = exc;
      b8.imem_ready = rdy; b8.stall = stl; b8.redirect_valid = rv;
      b8.redirect_target = tgt[7:0]; b8.exc_valid = exc;
      #1;
      check("pc_plus_inc32", b32.pc_plus_inc, (m32.pc + 32'd4) & M32);
      check("pc_plus_inc8", {24'h0, b8.pc_plus_inc}, (m8.pc + 32'd4) & M8);
      check("misaligned32", {31'h0, b32.misaligned}, {31'h0, rv && (tgt[1:0] != 2'b00)});
      n32 = model_next(m32, rdy, stl, rv, tgt, exc, M32);
      n8  = model_next(m8, rdy, stl, rv, tgt, exc, M8);
      q32.push_back({n32.pc, n32.fv, n32.pv});
      q8.push_back({n8.pc, n8.fv, n8.pv});
      @(posedge clk);
      #1;
      e = q32.pop_front();
      check("pc32", b32.pc, e.pc);
      check("fetch_valid32", {31'h0, b32.fetch_valid}, {31'h0, e.fv});
      check("pending32", {31'h0, b32.redirect_pending}, {31'h0, e.pv});
      e = q8.pop_front();
      check("pc8", {24'h0, b8.pc}, e.pc);
      check("pending8", {31'h0, b8.redirect_pending}, {31'h0, e.pv});
      m32 = n32;
      m8  = n8;
   endtask

   task automatic adv(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
   endtask

   initial begin
      m32 = model_reset();
      m8  = model_reset();
      b32.imem_ready = 1'b0; b32.stall = 1'b0; b32.redirect_valid = 1'b0;
      b32.redirect_target = '0; b32.exc_valid = 1'b0;
      b8.imem_ready = 1'b0; b8.stall = 1'b0; b8.redirect_valid = 1'b0;
      b8.redirect_target = '0; b8.exc_valid = 1'b0;
      #12;
      check("rst_pc", b32.pc, 32'h0);
      check("rst_fetch_valid", {31'h0, b32.fetch_valid}, 32'h0);
      check("rst_pending", {31'h0, b32.redirect_pending}, 32'h0);
      check("rst_pc_plus_inc", b32.pc_plus_inc, 32'h4);
      rst = 1'b0;

      adv(1);
      check("boot_pc", b32.pc, 32'h0);
      check("boot_fetch_valid", {31'h0, b32.fetch_valid}, 32'h1);
      adv(3);
      check("seq_pc", b32.pc, 32'hC);
      adv(1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      check("stall_hold", b32.pc, 32'h10);
      adv(1);
      check("stall_release", b32.pc, 32'h14);
      adv(3);
      check("at_0x20", b32.pc, 32'h20);

      step(1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
      check("buf_pending", {31'h0, b32.redirect_pending}, 32'h1);
      check("buf_pc_hold", b32.pc, 32'h20);
      adv(1);
`ifdef BRANCH_DELAY_SLOT_EN
      check("buf_slot", b32.pc, 32'h24);
      adv(1);
`endif
      check("buf_apply", b32.pc, 32'h100);
      check("buf_cleared", {31'h0, b32.redirect_pending}, 32'h0);

      step(1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check("exc_pc", b32.pc, 32'h180);
      check("exc_pc8", {24'h0, b8.pc}, 32'h80);
      check("exc_clears", {31'h0, b32.redirect_pending}, 32'h0);
      step(1'b1, 1'b0, 1'b1, 32'h303, 1'b0);
`ifdef BRANCH_DELAY_SLOT_EN
      adv(1);
`endif
      check("align_pc", b32.pc, 32'h300);

      step(1'b1, 1'b0, 1'b1, 32'hFC, 1'b0);
`ifdef BRANCH_DELAY_SLOT_EN
      adv(1);
`endif
      check("at_0xfc8", {24'h0, b8.pc}, 32'hFC);
      adv(1);
      check("wrap8", {24'h0, b8.pc}, 32'h0);
      check("nowrap32", b32.pc, 32'h100);

      step(1'b1, 1'b0, 1'b1, 32'h40, 1'b0);
`ifdef BRANCH_DELAY_SLOT_EN
      adv(1);
`endif
      step(1'b1, 1'b0, 1'b1, 32'h80, 1'b0);
`ifdef BRANCH_DELAY_SLOT_EN
      check("ds_slot", b32.pc, 32'h44);
      adv(1);
`endif
      check("ds_target", b32.pc, 32'h80);

      step(1'b0, 1'b0, 1'b1, 32'h500, 1'b0);
      step(1'b1, 1'b0, 1'b1, 32'h600, 1'b0);
`ifdef BRANCH_DELAY_SLOT_EN
      adv(1);
`endif
      check("live_wins", b32.pc, 32'h600);

      step(1'b0, 1'b1, 1'b1, 32'h700, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_pc", b32.pc, 32'h0);
      check("async_rst_pending", {31'h0, b32.redirect_pending}, 32'h0);
      check("async_rst_fv", {31'h0, b32.fetch_valid}, 32'h0);
      check("async_rst_pc8", {24'h0, b8.pc}, 32'h0);
      m32 = model_reset();
      m8  = model_reset();
      #2;
      rst = 1'b0;
      adv(2);
      check("post_rst_pc", b32.pc, 32'h4);

      for (int i = 0; i < 60; i++) begin
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
              1'($urandom_range(0, 3) == 0), $urandom & 32'h0000_0FFF,
              1'($urandom_range(0, 15) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter unit; supersedes the fixed +4 incrementer in the fetch stage.
- Holds the architectural PC register and selects the next PC from these sources: sequential increment, branch/jump redirect, or exception vector.
- Honours fetch back-pressure and pipeline stalls.
- A redirect that arrives while the PC is frozen is buffered until the PC can advance, so it is never lost.

Parameters:
- WIDTH, 32, PC width in bits.
- INC, 4, sequential increment in bytes; must be a power of two ≥1.
- RESET_PC, 0, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0180, exception entry address; truncated to WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- imem_ready  input  1  instruction memory accepts the fetch at pc this cycle.
- stall  input  1  pipeline hazard stall; freezes the PC.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_target  input  WIDTH  redirect destination.
- exc_valid  input  1  exception/trap request.
- pc  output  WIDTH  current fetch address (registered).
- pc_plus_inc  output  WIDTH  pc + INC, combinational, wraps modulo 2^WIDTH.
- fetch_valid  output  1  high when pc is a live fetch.
- redirect_pending  output  1  a buffered redirect is waiting.
- misaligned  output  1  redirect_target low log2(INC) bits are nonzero while redirect_valid is high; combinational.

Behaviour:
- Reset (async, any time, including mid-stall): pc=RESET_PC, pending cleared, fetch_valid=0. fetch_valid becomes 1 on the first clock edge after rst deasserts. pc_plus_inc=RESET_PC+INC.
- advance = fetch_valid & imem_ready & ~stall. While fetch_valid=0, the first edge sets fetch_valid=1 and leaves pc unchanged.
- Next-PC priority, evaluated each edge:
  1. exc_valid: pc<=EXC_VECTOR regardless of advance or stall; pending cleared.
  2. redirect_valid & advance: pc<=aligned target; pending cleared.
  3. redirect_valid & ~advance: target latched into pending buffer (a newer redirect overwrites an older one); pc holds.
  4. pending & advance: pc<=pending target; pending cleared.
  5. advance: pc<=pc+INC.
  6. otherwise: pc holds.
- Aligned target = redirect_target with the low log2(INC) bits forced to 0. misaligned is a status flag only and does not block the redirect.
- Simultaneous redirect_valid and pending with advance: the live redirect wins and the pending target is discarded.
- Wrap: pc at 2^WIDTH−INC advancing goes to 0. No flag.
- Latency: a redirect issued on an advancing cycle appears on pc the next cycle (1-cycle redirect).

Optional Feature:
- Macro BRANCH_DELAY_SLOT_EN.
- Defined (MIPS delay-slot semantics):
  - A redirect_valid accepted on an advancing cycle sets pc<=pc+INC (the delay slot) and places the target in the pending buffer.
  - The target is applied on the next advance.
  - A redirect on a non-advancing cycle is buffered as in rule 3; on the first subsequent advance it behaves as an accepted redirect (slot, then target).
  - exc_valid still overrides immediately and clears both the slot and pending state.
- Undefined: the rules above apply unchanged; there is no slot.

Test Plan:
- Reset: rst pulse, then 4 cycles with imem_ready=1, stall=0 -> pc sequence 0x0, 0x0 (fetch_valid rises), 0x4, 0x8, 0xC; pc_plus_inc always pc+4.
- Stall hold: at pc=0x10, stall=1 for 3 cycles -> pc stays 0x10; after stall drops -> 0x14.
- Buffered redirect: pc=0x20, imem_ready=0, redirect_valid=1, target=0x100 for 1 cycle -> redirect_pending=1, pc=0x20; imem_ready=1 -> next pc=0x100, pending=0.
- Priority and alignment: pending=0x200 while exc_valid=1 -> pc=0x180, pending cleared. Then redirect target=0x303 -> misaligned=1, pc becomes 0x300.
- Wrap and reset mid-operation: WIDTH=8, pc=0xFC advance -> 0x00. Assert rst while pending=1 -> pc=RESET_PC immediately without a clock edge, pending=0.
- Delay slot (BRANCH_DELAY_SLOT_EN): pc=0x40, redirect target=0x80 on an advancing cycle -> pc 0x44 then 0x80. With the macro undefined -> pc 0x80 directly.
